// File: rtl/seg_table_sram.sv
// Segment translation table: clear-on-reset sweep, 1-cycle lookup port, config write/read port.
// Optional macro SEG_TABLE_PARITY_EN adds per-entry even parity, sticky par_err and cfg_wpar_inv.
module seg_table_sram #(
  parameter int unsigned IDX_W   = 16,
  parameter int unsigned DEPTH   = 1 << IDX_W,
  parameter int unsigned ENTRY_W = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               axi_sram_req,
  input  logic [IDX_W-1:0]   axi_sram_addr,
  output logic [ENTRY_W-1:0] sram_rdata,
  output logic               init_done,
  input  logic               cfg_wvalid,
  input  logic [IDX_W-1:0]   cfg_widx,
  input  logic [ENTRY_W-1:0] cfg_wdata,
  output logic               cfg_wready,
  input  logic               cfg_rvalid,
  input  logic [IDX_W-1:0]   cfg_ridx,
  output logic               cfg_rready,
  output logic [ENTRY_W-1:0] cfg_rdata,
  output logic               cfg_rack,
`ifdef SEG_TABLE_PARITY_EN
  input  logic               cfg_wpar_inv,
`endif
  output logic               par_err
);

  localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 32'd1);
`ifdef SEG_TABLE_PARITY_EN
  localparam int unsigned MEM_W = ENTRY_W + 1;
`else
  localparam int unsigned MEM_W = ENTRY_W;
`endif

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  function automatic logic in_range_f(input logic [IDX_W-1:0] idx);
    return (32'(idx) < DEPTH);
  endfunction

`ifdef SEG_TABLE_PARITY_EN
  function automatic logic par_f(input logic [ENTRY_W-1:0] d);
    return ^d;
  endfunction
`endif

  state_t             state_r, state_next_s;
  logic [AW-1:0]      ptr_r;
  logic [MEM_W-1:0]   mem_r [DEPTH];
  logic               cfg_wready_s, cfg_rready_s, wr_cfg_s, cfg_racc_s;
  logic               wr_en_s;
  logic [AW-1:0]      wr_addr_s;
  logic [MEM_W-1:0]   wr_word_s, cfg_word_s, rd_word_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [ENTRY_W-1:0] rd_data_s, lk_data_s, cr_data_s;
  logic               rd_perr_s;
  logic               lk_valid_s, lk_byp_s, cr_valid_s, cr_byp_s;
  logic [ENTRY_W-1:0] sram_rdata_r, cfg_rdata_r;
  logic               cfg_rack_r, init_done_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_INIT;
    else     state_r <= state_next_s;
  end

  // Next-state logic: leave INIT after the last entry is cleared
  always_comb begin
    state_next_s = ST_INIT;
    case (state_r)
      ST_INIT:  state_next_s = (ptr_r == LAST) ? ST_READY : ST_INIT;
      ST_READY: state_next_s = ST_READY;
      default:  state_next_s = ST_INIT;
    endcase
  end

  // Handshake outputs: lookups own the single read port, so config reads stall behind them
  always_comb begin
    cfg_wready_s = 1'b0;
    cfg_rready_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        cfg_wready_s = 1'b0;
        cfg_rready_s = 1'b0;
      end
      ST_READY: begin
        cfg_wready_s = !rst;
        cfg_rready_s = !rst && !axi_sram_req;
      end
      default: begin
        cfg_wready_s = 1'b0;
        cfg_rready_s = 1'b0;
      end
    endcase
  end

  // Clear-sweep pointer; holds at the last entry rather than wrapping
  always_ff @(posedge clk) begin
    if (rst)                                        ptr_r <= '0;
    else if (state_r == ST_INIT && ptr_r != LAST)   ptr_r <= ptr_r + AW'(32'd1);
    else                                            ptr_r <= ptr_r;
  end

  assign wr_cfg_s   = cfg_wvalid && cfg_wready_s && in_range_f(cfg_widx);
  assign cfg_racc_s = cfg_rvalid && cfg_rready_s;

`ifdef SEG_TABLE_PARITY_EN
  assign cfg_word_s = {par_f(cfg_wdata) ^ cfg_wpar_inv, cfg_wdata};
`else
  assign cfg_word_s = cfg_wdata;
`endif

  // Write port mux: sweep zeros during INIT, config writes afterwards
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    wr_word_s = '0;
    if (state_r == ST_INIT) begin
      wr_en_s   = !rst;
      wr_addr_s = ptr_r;
      wr_word_s = '0;
    end else begin
      wr_en_s   = wr_cfg_s;
      wr_addr_s = cfg_widx[AW-1:0];
      wr_word_s = cfg_word_s;
    end
  end

  // Table storage
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_addr_s] <= wr_word_s;
  end

  assign rd_idx_s  = axi_sram_req ? axi_sram_addr : cfg_ridx;
  assign rd_word_s = mem_r[rd_idx_s[AW-1:0]];
  assign rd_data_s = rd_word_s[ENTRY_W-1:0];
`ifdef SEG_TABLE_PARITY_EN
  assign rd_perr_s = (par_f(rd_data_s) != rd_word_s[MEM_W-1]);
`else
  assign rd_perr_s = 1'b0;
`endif

  assign lk_valid_s = (state_r == ST_READY) && in_range_f(axi_sram_addr);
  assign lk_byp_s   = wr_cfg_s && (cfg_widx == axi_sram_addr);
  assign cr_valid_s = (state_r == ST_READY) && in_range_f(cfg_ridx);
  assign cr_byp_s   = wr_cfg_s && (cfg_widx == cfg_ridx);

  // Lookup result: deny outside READY/range or on parity error, write-first bypass
  always_comb begin
    lk_data_s = '0;
    if (!lk_valid_s)    lk_data_s = '0;
    else if (lk_byp_s)  lk_data_s = cfg_wdata;
    else if (rd_perr_s) lk_data_s = '0;
    else                lk_data_s = rd_data_s;
  end

  // Config read result, same rules as a lookup
  always_comb begin
    cr_data_s = '0;
    if (!cr_valid_s)    cr_data_s = '0;
    else if (cr_byp_s)  cr_data_s = cfg_wdata;
    else if (rd_perr_s) cr_data_s = '0;
    else                cr_data_s = rd_data_s;
  end

  // Lookup data register, holds until the next request
  always_ff @(posedge clk) begin
    if (rst)               sram_rdata_r <= '0;
    else if (axi_sram_req) sram_rdata_r <= lk_data_s;
    else                   sram_rdata_r <= sram_rdata_r;
  end

  // Config read data/ack registers; reset drops any read accepted this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rdata_r <= '0;
      cfg_rack_r  <= 1'b0;
    end else begin
      cfg_rack_r  <= cfg_racc_s;
      cfg_rdata_r <= cfg_racc_s ? cr_data_s : cfg_rdata_r;
    end
  end

  // init_done tracks the READY state
  always_ff @(posedge clk) begin
    if (rst) init_done_r <= 1'b0;
    else     init_done_r <= (state_next_s == ST_READY);
  end

`ifdef SEG_TABLE_PARITY_EN
  logic par_err_r;
  // Sticky parity error, only from reads that actually came out of the array
  always_ff @(posedge clk) begin
    if (rst)
      par_err_r <= 1'b0;
    else if (rd_perr_s && ((axi_sram_req && lk_valid_s && !lk_byp_s) ||
                           (cfg_racc_s && cr_valid_s && !cr_byp_s)))
      par_err_r <= 1'b1;
    else
      par_err_r <= par_err_r;
  end
  assign par_err = par_err_r;
`else
  assign par_err = 1'b0;
`endif

  assign sram_rdata = sram_rdata_r;
  assign cfg_rdata  = cfg_rdata_r;
  assign cfg_rack   = cfg_rack_r;
  assign init_done  = init_done_r;
  assign cfg_wready = cfg_wready_s;
  assign cfg_rready = cfg_rready_s;

endmodule

// File: tb/tb_seg_table_sram.sv
// Self-checking bench for seg_table_sram (DEPTH=16 so out-of-range indices are reachable).
module tb_seg_table_sram;
  localparam int unsigned IDX_W = 16, DEPTH = 16, ENTRY_W = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic axi_sram_req = 1'b0;
  logic [IDX_W-1:0] axi_sram_addr = '0;
  logic [ENTRY_W-1:0] sram_rdata;
  logic init_done;
  logic cfg_wvalid = 1'b0;
  logic [IDX_W-1:0] cfg_widx = '0;
  logic [ENTRY_W-1:0] cfg_wdata = '0;
  logic cfg_wready;
  logic cfg_rvalid = 1'b0;
  logic [IDX_W-1:0] cfg_ridx = '0;
  logic cfg_rready;
  logic [ENTRY_W-1:0] cfg_rdata;
  logic cfg_rack;
  logic par_err;
`ifdef SEG_TABLE_PARITY_EN
  logic cfg_wpar_inv = 1'b0;
`endif

  always #5 clk = ~clk;

  seg_table_sram #(.IDX_W(IDX_W), .DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) dut (
    .clk(clk), .rst(rst),
    .axi_sram_req(axi_sram_req), .axi_sram_addr(axi_sram_addr), .sram_rdata(sram_rdata),
    .init_done(init_done),
    .cfg_wvalid(cfg_wvalid), .cfg_widx(cfg_widx), .cfg_wdata(cfg_wdata), .cfg_wready(cfg_wready),
    .cfg_rvalid(cfg_rvalid), .cfg_ridx(cfg_ridx), .cfg_rready(cfg_rready),
    .cfg_rdata(cfg_rdata), .cfg_rack(cfg_rack),
`ifdef SEG_TABLE_PARITY_EN
    .cfg_wpar_inv(cfg_wpar_inv),
`endif
    .par_err(par_err)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [ENTRY_W-1:0] model_mem [DEPTH];
  logic [ENTRY_W-1:0] exp_sram = '0;
  logic [ENTRY_W-1:0] exp_cfg = '0;

  typedef struct {
    logic               wv;
    logic [IDX_W-1:0]   widx;
    logic [ENTRY_W-1:0] wdata;
    logic               req;
    logic [IDX_W-1:0]   addr;
    logic               rv;
    logic [IDX_W-1:0]   ridx;
    logic [ENTRY_W-1:0] e_sram;
    logic               e_rack;
    logic [ENTRY_W-1:0] e_cfg;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    axi_sram_req = 1'b0; axi_sram_addr = '0;
    cfg_wvalid = 1'b0; cfg_widx = '0; cfg_wdata = '0;
    cfg_rvalid = 1'b0; cfg_ridx = '0;
`ifdef SEG_TABLE_PARITY_EN
    cfg_wpar_inv = 1'b0;
`endif
  endtask

  // Expected table view of an index this cycle, including same-cycle write-first bypass
  function automatic logic [ENTRY_W-1:0] expect_read(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= int'(DEPTH)) return '0;
    if (cfg_wvalid && cfg_widx == idx) return cfg_wdata;
    return model_mem[int'(idx)];
  endfunction

  task automatic model_write();
    if (cfg_wvalid && int'(cfg_widx) < int'(DEPTH)) model_mem[int'(cfg_widx)] = cfg_wdata;
  endtask

  task automatic start_reset(input string name);
    rst = 1'b1;
    step();
    chk({name, "_rst_sram"}, sram_rdata, 0);
    chk({name, "_rst_cfg"}, cfg_rdata, 0);
    chk({name, "_rst_rack"}, cfg_rack, 0);
    chk({name, "_rst_done"}, init_done, 0);
    chk({name, "_rst_par"}, par_err, 0);
    rst = 1'b0;
    idle();
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    exp_sram = '0;
    exp_cfg = '0;
  endtask

  task automatic finish_init(input string name);
    int cyc;
    axi_sram_req = 1'b1; axi_sram_addr = 16'd5;
    step();
    cyc = 1;
    axi_sram_req = 1'b0;
    chk({name, "_init_lookup"}, sram_rdata, 0);
    chk({name, "_init_wready"}, cfg_wready, 0);
    chk({name, "_init_rready"}, cfg_rready, 0);
    while (init_done !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    chk({name, "_init_cycles"}, cyc, 16);
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'd3,  23'h600123, 1'b0, 16'd0,  1'b0, 16'd0,  23'h000000, 1'b0, 23'h000000};
    vecs[1] = '{1'b0, 16'd0,  23'h000000, 1'b1, 16'd3,  1'b0, 16'd0,  23'h600123, 1'b0, 23'h000000};
    vecs[2] = '{1'b0, 16'd0,  23'h000000, 1'b1, 16'd4,  1'b0, 16'd0,  23'h000000, 1'b0, 23'h000000};
    vecs[3] = '{1'b1, 16'd7,  23'h2ABCDE, 1'b1, 16'd7,  1'b0, 16'd0,  23'h2ABCDE, 1'b0, 23'h000000};
    vecs[4] = '{1'b1, 16'd20, 23'h1FFFFF, 1'b1, 16'd20, 1'b0, 16'd0,  23'h000000, 1'b0, 23'h000000};
    vecs[5] = '{1'b0, 16'd0,  23'h000000, 1'b1, 16'd4,  1'b0, 16'd0,  23'h000000, 1'b0, 23'h000000};
    vecs[6] = '{1'b0, 16'd0,  23'h000000, 1'b0, 16'd0,  1'b1, 16'd7,  23'h000000, 1'b1, 23'h2ABCDE};
    vecs[7] = '{1'b0, 16'd0,  23'h000000, 1'b0, 16'd0,  1'b0, 16'd0,  23'h000000, 1'b0, 23'h2ABCDE};
    vecs[8] = '{1'b1, 16'd15, 23'h400001, 1'b0, 16'd0,  1'b1, 16'd15, 23'h000000, 1'b1, 23'h400001};
    vecs[9] = '{1'b0, 16'd0,  23'h000000, 1'b0, 16'd0,  1'b1, 16'd20, 23'h000000, 1'b1, 23'h000000};

    idle();
    start_reset("r0");
    finish_init("r0");
    chk("ready_wready", cfg_wready, 1);

    for (int v = 0; v < 10; v++) begin
      cfg_wvalid = vecs[v].wv; cfg_widx = vecs[v].widx; cfg_wdata = vecs[v].wdata;
      axi_sram_req = vecs[v].req; axi_sram_addr = vecs[v].addr;
      cfg_rvalid = vecs[v].rv; cfg_ridx = vecs[v].ridx;
      model_write();
      step();
      idle();
      chk($sformatf("vec%0d_sram", v), sram_rdata, vecs[v].e_sram);
      chk($sformatf("vec%0d_rack", v), cfg_rack, vecs[v].e_rack);
      chk($sformatf("vec%0d_cfg", v), cfg_rdata, vecs[v].e_cfg);
    end
    exp_sram = vecs[9].e_sram;
    exp_cfg = vecs[9].e_cfg;

    // Config read of idx 3 held while lookups occupy the read port
    cfg_rvalid = 1'b1; cfg_ridx = 16'd3;
    for (int c = 0; c < 3; c++) begin
      axi_sram_req = 1'b1; axi_sram_addr = 16'd3;
      #1;
      chk($sformatf("stall%0d_rready", c), cfg_rready, 0);
      step();
      chk($sformatf("stall%0d_rack", c), cfg_rack, 0);
      chk($sformatf("stall%0d_sram", c), sram_rdata, 23'h600123);
    end
    axi_sram_req = 1'b0;
    #1;
    chk("stall_release_rready", cfg_rready, 1);
    step();
    cfg_rvalid = 1'b0;
    chk("stall_rack", cfg_rack, 1);
    chk("stall_cfg", cfg_rdata, 23'h600123);
    exp_sram = 23'h600123;
    exp_cfg = 23'h600123;

    // Randomized traffic against the array model
    for (int i = 0; i < 400; i++) begin
      logic racc;
      cfg_wvalid = ($urandom & 32'd1) != 32'd0;
      cfg_widx = 16'($urandom_range(19, 0));
      cfg_wdata = 23'($urandom);
      axi_sram_req = ($urandom_range(9, 0) < 6);
      axi_sram_addr = 16'($urandom_range(19, 0));
      cfg_rvalid = ($urandom & 32'd1) != 32'd0;
      cfg_ridx = ($urandom_range(3, 0) == 0) ? cfg_widx : 16'($urandom_range(19, 0));
      if (($urandom_range(7, 0) == 0)) axi_sram_addr = cfg_widx;
      #1;
      chk("rnd_rready", cfg_rready, !axi_sram_req);
      chk("rnd_wready", cfg_wready, 1);
      racc = cfg_rvalid && !axi_sram_req;
      if (axi_sram_req) exp_sram = expect_read(axi_sram_addr);
      if (racc) exp_cfg = expect_read(cfg_ridx);
      model_write();
      step();
      chk("rnd_sram", sram_rdata, exp_sram);
      chk("rnd_rack", cfg_rack, racc);
      chk("rnd_cfg", cfg_rdata, exp_cfg);
    end
    idle();
    step();

`ifdef SEG_TABLE_PARITY_EN
    cfg_wvalid = 1'b1; cfg_widx = 16'd9; cfg_wdata = 23'h7FFFFF; cfg_wpar_inv = 1'b1;
    step();
    idle();
    axi_sram_req = 1'b1; axi_sram_addr = 16'd9;
    step();
    idle();
    chk("par_lookup", sram_rdata, 0);
    chk("par_err_set", par_err, 1);
    step();
    step();
    chk("par_err_sticky", par_err, 1);
`endif

    // Reset while a config read is being accepted, then again mid-INIT
    cfg_rvalid = 1'b1; cfg_ridx = 16'd3;
    start_reset("r1");
    for (int c = 0; c < 7; c++) step();
    chk("r1_mid_init_done", init_done, 0);
    start_reset("r2");
    finish_init("r2");

    axi_sram_req = 1'b1; axi_sram_addr = 16'd3;
    step();
    chk("post_lookup3", sram_rdata, 0);
    axi_sram_addr = 16'd7;
    step();
    chk("post_lookup7", sram_rdata, 0);
    axi_sram_req = 1'b0;
    cfg_rvalid = 1'b1; cfg_ridx = 16'd15;
    step();
    idle();
    chk("post_cfg15_rack", cfg_rack, 1);
    chk("post_cfg15", cfg_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
